// File: rtl/regfile_pkg.sv
// Shared defaults and reset-value helper for the multi-port register file.
package regfile_pkg;

  localparam int unsigned REGFILE_DATA_W   = 32;
  localparam int unsigned REGFILE_DEPTH    = 32;
  localparam int unsigned REGFILE_NUM_READ = 2;

  // Register i comes out of reset holding its own index (register 0 holds 0).
  function automatic int unsigned regfile_init(input int unsigned idx);
    return idx;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: write clears, reserve sets (reserve wins), exposes next-state vector and registered popcount.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH    = REGFILE_DEPTH,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DEPTH-1:0]  pend_nxt,
  output logic [ADDR_W:0]   busy_cnt
);

  logic [DEPTH-1:0] pend;
  logic [ADDR_W:0]  cnt_nxt;

  always_comb begin
    pend_nxt = pend;
    if (wr_en && !(ZERO_REG != 0 && wr_addr == '0))
      pend_nxt[wr_addr] = 1'b0;
    if (rsv_valid && !(ZERO_REG != 0 && rsv_addr == '0))
      pend_nxt[rsv_addr] = 1'b1;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, pend_nxt[i]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend     <= '0;
      busy_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-first bypass and pending-write scoreboard.
// Optional debug read port enabled by defining REGFILE_DEBUG_PORT_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = REGFILE_DATA_W,
  parameter int unsigned DEPTH    = REGFILE_DEPTH,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned NUM_READ = REGFILE_NUM_READ,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
  output logic [NUM_READ*DATA_W-1:0]   rd_data,
  output logic [NUM_READ-1:0]          rd_busy,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         rsv_valid,
  input  logic [ADDR_W-1:0]            rsv_addr,
  output logic [ADDR_W:0]              busy_cnt
`ifdef REGFILE_DEBUG_PORT_EN
  ,
  input  logic [ADDR_W-1:0]            dbg_addr,
  output logic [DATA_W-1:0]            dbg_data
`endif
);

  logic [DATA_W-1:0]          mem [DEPTH];
  logic [DEPTH-1:0]           pend_nxt;
  logic [NUM_READ*DATA_W-1:0] rd_data_nxt;
  logic [NUM_READ-1:0]        rd_busy_nxt;
  logic                       wr_ok;

  assign wr_ok = we && !(ZERO_REG != 0 && wr_addr == '0);

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (we),
    .wr_addr   (wr_addr),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .pend_nxt  (pend_nxt),
    .busy_cnt  (busy_cnt)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[i] <= DATA_W'(regfile_init(i));
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read path sees the post-write value and post-update pending bit of this edge.
  always_comb begin
    rd_data_nxt = '0;
    rd_busy_nxt = '0;
    for (int unsigned k = 0; k < NUM_READ; k++) begin
      if (!(ZERO_REG != 0 && rd_addr[k*ADDR_W +: ADDR_W] == '0)) begin
        if (we && wr_addr == rd_addr[k*ADDR_W +: ADDR_W])
          rd_data_nxt[k*DATA_W +: DATA_W] = wr_data;
        else
          rd_data_nxt[k*DATA_W +: DATA_W] = mem[rd_addr[k*ADDR_W +: ADDR_W]];
        rd_busy_nxt[k] = pend_nxt[rd_addr[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
      rd_busy <= '0;
    end else begin
      rd_data <= rd_data_nxt;
      rd_busy <= rd_busy_nxt;
    end
  end

`ifdef REGFILE_DEBUG_PORT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) dbg_data <= '0;
    else        dbg_data <= mem[dbg_addr];
  end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp against an array/scoreboard reference model.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int DP = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NR*AW-1:0]  rd_addr = '0;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              we = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DW-1:0]     wr_data = '0;
  logic              rsv_valid = 1'b0;
  logic [AW-1:0]     rsv_addr = '0;
  logic [AW:0]       busy_cnt;
`ifdef REGFILE_DEBUG_PORT_EN
  logic [AW-1:0]     dbg_addr = '0;
  logic [DW-1:0]     dbg_data;
`endif

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] m_reg [DP];
  bit            m_pend [DP];
  logic [DW-1:0] exp_d [NR];
  logic          exp_b [NR];
  int            exp_cnt = 0;

  regfile_mp #(
    .DATA_W   (DW),
    .DEPTH    (DP),
    .NUM_READ (NR),
    .ZERO_REG (1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .busy_cnt  (busy_cnt)
`ifdef REGFILE_DEBUG_PORT_EN
    ,
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
`endif
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    for (int i = 0; i < DP; i++) begin
      m_reg[i]  = DW'(i);
      m_pend[i] = 1'b0;
    end
    exp_cnt = 0;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  // Apply the architectural update for the current inputs, derive what reads see, then clock once.
  task automatic step();
    logic [AW-1:0] a;
    if (we && wr_addr != 0) begin
      m_reg[wr_addr]  = wr_data;
      m_pend[wr_addr] = 1'b0;
    end
    if (rsv_valid && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < DP; i++) exp_cnt += int'(m_pend[i]);
    for (int k = 0; k < NR; k++) begin
      a = rd_addr[k*AW +: AW];
      exp_d[k] = (a == 0) ? '0 : m_reg[a];
      exp_b[k] = (a == 0) ? 1'b0 : m_pend[a];
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    total++; if (rd_busy !== '0) begin bad++; $display("FAIL reset_rd_busy got %b exp 0", rd_busy); end
    total++; if (busy_cnt !== '0) begin bad++; $display("FAIL reset_busy_cnt got %0d exp 0", busy_cnt); end
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    set_rd(0, 5'd5);
    set_rd(1, 5'd31);
`ifdef REGFILE_DEBUG_PORT_EN
    dbg_addr = 5'd12;
`endif
    step();
    total++; if (rd_data[0*DW +: DW] !== 32'd5) begin bad++; $display("FAIL reset_read5 got %h exp 5", rd_data[0*DW +: DW]); end
    total++; if (rd_data[1*DW +: DW] !== 32'd31) begin bad++; $display("FAIL reset_read31 got %h exp 1f", rd_data[1*DW +: DW]); end
    total++; if (rd_busy !== 2'b00) begin bad++; $display("FAIL reset_busy_after got %b exp 00", rd_busy); end
    total++; if (busy_cnt !== 0) begin bad++; $display("FAIL reset_cnt_after got %0d exp 0", busy_cnt); end
`ifdef REGFILE_DEBUG_PORT_EN
    total++; if (dbg_data !== 32'd12) begin bad++; $display("FAIL dbg_after_reset got %h exp c", dbg_data); end
`endif
  endtask

  task automatic test_bypass();
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF;
    set_rd(0, 5'd7); set_rd(1, 5'd6);
    step();
    total++; if (rd_data[0*DW +: DW] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bypass_port0 got %h exp deadbeef", rd_data[0*DW +: DW]); end
    total++; if (rd_data[1*DW +: DW] !== exp_d[1]) begin bad++; $display("FAIL bypass_port1 got %h exp %h", rd_data[1*DW +: DW], exp_d[1]); end
    we = 1'b0;
    set_rd(1, 5'd7);
    step();
    total++; if (rd_data !== {2{32'hDEAD_BEEF}}) begin bad++; $display("FAIL bypass_stored got %h exp both deadbeef", rd_data); end
  endtask

  task automatic test_zero_reg();
    int prev;
    prev = exp_cnt;
    we = 1'b1; wr_addr = '0; wr_data = 32'hFFFF_FFFF;
    rsv_valid = 1'b1; rsv_addr = '0;
    set_rd(0, '0); set_rd(1, '0);
    step();
    we = 1'b0; rsv_valid = 1'b0;
    total++; if (rd_data !== '0) begin bad++; $display("FAIL zero_data got %h exp 0", rd_data); end
    total++; if (rd_busy !== '0) begin bad++; $display("FAIL zero_busy got %b exp 0", rd_busy); end
    total++; if (busy_cnt !== (AW+1)'(prev)) begin bad++; $display("FAIL zero_cnt got %0d exp %0d", busy_cnt, prev); end
    step();
    total++; if (rd_data[0*DW +: DW] !== '0) begin bad++; $display("FAIL zero_data_late got %h exp 0", rd_data[0*DW +: DW]); end
  endtask

  task automatic test_scoreboard();
    logic [DW-1:0] d;
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    step();
    rsv_addr = 5'd9;
    step();
    rsv_valid = 1'b0;
    total++; if (busy_cnt !== 2) begin bad++; $display("FAIL sb_cnt2 got %0d exp 2", busy_cnt); end
    set_rd(0, 5'd3); set_rd(1, 5'd9);
    step();
    total++; if (rd_busy !== 2'b11) begin bad++; $display("FAIL sb_busy3 got %b exp 11", rd_busy); end
    d = $urandom;
    we = 1'b1; wr_addr = 5'd3; wr_data = d;
    step();
    we = 1'b0;
    total++; if (rd_busy !== 2'b10) begin bad++; $display("FAIL sb_clear3 got %b exp 10", rd_busy); end
    total++; if (busy_cnt !== 1) begin bad++; $display("FAIL sb_cnt1 got %0d exp 1", busy_cnt); end
    total++; if (rd_data[0*DW +: DW] !== d) begin bad++; $display("FAIL sb_data3 got %h exp %h", rd_data[0*DW +: DW], d); end
  endtask

  task automatic test_collision();
    we = 1'b1; wr_addr = 5'd4; wr_data = 32'h55;
    rsv_valid = 1'b1; rsv_addr = 5'd4;
    set_rd(0, 5'd4); set_rd(1, 5'd4);
    step();
    we = 1'b0; rsv_valid = 1'b0;
    total++; if (rd_data !== {2{32'h55}}) begin bad++; $display("FAIL coll_data got %h exp both 55", rd_data); end
    total++; if (rd_busy !== 2'b11) begin bad++; $display("FAIL coll_busy got %b exp 11", rd_busy); end
    step();
    total++; if (rd_data[0*DW +: DW] !== 32'h55 || rd_busy[0] !== 1'b1) begin bad++; $display("FAIL coll_hold got %h/%b exp 55/1", rd_data[0*DW +: DW], rd_busy[0]); end
  endtask

  task automatic test_full();
    for (int a = 0; a < DP; a++) begin
      rsv_valid = 1'b1; rsv_addr = AW'(a);
      step();
    end
    rsv_valid = 1'b0;
    total++; if (busy_cnt !== 31) begin bad++; $display("FAIL full_cnt got %0d exp 31", busy_cnt); end
    for (int a = 0; a < DP; a++) begin
      we = 1'b1; wr_addr = AW'(a); wr_data = $urandom;
      step();
      total++; if (busy_cnt !== (AW+1)'(exp_cnt)) begin bad++; $display("FAIL drain_cnt a=%0d got %0d exp %0d", a, busy_cnt, exp_cnt); end
    end
    we = 1'b0;
    total++; if (busy_cnt !== 0) begin bad++; $display("FAIL drain_empty got %0d exp 0", busy_cnt); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      we        = 1'($urandom_range(0, 1));
      wr_addr   = AW'($urandom_range(0, 7));
      wr_data   = $urandom;
      rsv_valid = 1'($urandom_range(0, 1));
      rsv_addr  = AW'($urandom_range(0, 7));
      set_rd(0, AW'($urandom_range(0, 7)));
      set_rd(1, (n % 4 == 0) ? rd_addr[0 +: AW] : AW'($urandom_range(0, 7)));
      step();
      for (int k = 0; k < NR; k++) begin
        total++; if (rd_data[k*DW +: DW] !== exp_d[k]) begin bad++; $display("FAIL rand_data n=%0d k=%0d got %h exp %h", n, k, rd_data[k*DW +: DW], exp_d[k]); end
        total++; if (rd_busy[k] !== exp_b[k]) begin bad++; $display("FAIL rand_busy n=%0d k=%0d got %b exp %b", n, k, rd_busy[k], exp_b[k]); end
      end
      total++; if (busy_cnt !== (AW+1)'(exp_cnt)) begin bad++; $display("FAIL rand_cnt n=%0d got %0d exp %0d", n, busy_cnt, exp_cnt); end
    end
    we = 1'b0; rsv_valid = 1'b0;
  endtask

`ifdef REGFILE_DEBUG_PORT_EN
  task automatic test_debug();
    logic [DW-1:0] e;
    for (int n = 0; n < 40; n++) begin
      dbg_addr  = AW'($urandom_range(0, 31));
      e         = m_reg[dbg_addr];
      we        = 1'b1;
      wr_addr   = (n % 2 == 0) ? dbg_addr : AW'($urandom_range(1, 31));
      wr_data   = $urandom;
      set_rd(0, wr_addr); set_rd(1, dbg_addr);
      step();
      total++; if (dbg_data !== e) begin bad++; $display("FAIL dbg_read n=%0d got %h exp %h", n, dbg_data, e); end
      total++; if (rd_data[0*DW +: DW] !== exp_d[0]) begin bad++; $display("FAIL dbg_func n=%0d got %h exp %h", n, rd_data[0*DW +: DW], exp_d[0]); end
    end
    we = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234_5678;
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    step();
    #2;
    reset = 1'b0;
    #1;
    total++; if (rd_data !== '0 || rd_busy !== '0 || busy_cnt !== '0) begin bad++; $display("FAIL midreset_async got %h/%b/%0d exp 0/0/0", rd_data, rd_busy, busy_cnt); end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    we = 1'b0; rsv_valid = 1'b0;
    set_rd(0, 5'd7); set_rd(1, 5'd31);
    step();
    total++; if (rd_data[0*DW +: DW] !== 32'd7) begin bad++; $display("FAIL midreset_r7 got %h exp 7", rd_data[0*DW +: DW]); end
    total++; if (rd_busy !== 2'b00 || busy_cnt !== 0) begin bad++; $display("FAIL midreset_sb got %b/%0d exp 00/0", rd_busy, busy_cnt); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_collision();
    test_full();
    test_random();
`ifdef REGFILE_DEBUG_PORT_EN
    test_debug();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
